piso_stream_arbiter: RTL

//  Shares the single piso_streamer 32-bit word input between N_REQ word sources (e.g. JFIF header gen, entropy coder, EOI inserter).

---
 rtl/jpeg_stream_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/piso_stream_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/jpeg_stream_pkg.sv
// Shared types for the JPEG output stream path: word type, arbiter FSM states.
package jpeg_stream_pkg;

   localparam int N_REQ_MAX = 8;

   typedef logic [31:0] word_t;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [2:0]       gnt_idx,
   output logic             any
);

   // Scan indices >= ptr first, then wrap around to indices below ptr
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!any && req[i] && (3'(i) >= ptr)) begin
            any     = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = 3'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!any && req[i] && (3'(i) < ptr)) begin
            any     = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = 3'(i);
         end
      end
   end

endmodule

// File: rtl/piso_stream_arbiter.sv
// Round-robin, packet-locked arbiter feeding the piso_streamer word input.
// Mirrors streamer occupancy cycle-exactly so the streamer can never overflow.
module piso_stream_arbiter
   import jpeg_stream_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int DEPTH_PWR = 4
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic [N_REQ*32-1:0] req_data,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ-1:0]    req_last,
   output logic [N_REQ-1:0]    req_ready,
   output logic [31:0]         din,
   output logic                din_valid,
   input  logic                strm_full,
   output logic [DEPTH_PWR:0]  occ,
   output logic [2:0]          grant_id,
   output logic                idle,
   output logic                err
);

   localparam int CAP = 1 << DEPTH_PWR;
   localparam int OW  = DEPTH_PWR + 1;

   arb_state_t       state_q, state_d;
   logic [2:0]       rr_ptr_q, rr_ptr_d;
   logic [2:0]       owner_q, owner_d;
   logic [2:0]       grant_id_q, grant_id_d;
   word_t            din_q, din_d;
   logic             din_valid_q, din_valid_d;
   logic [OW-1:0]    occ_q, occ_d, occ_plus;
   logic [1:0]       phase_q, phase_d;
   logic             err_q, err_d;
   logic             drain, credit_ok;
   logic [N_REQ-1:0] rr_gnt;
   logic [2:0]       rr_idx;
   logic             rr_any;
   logic [2:0]       sel_idx;
   logic             sel_last, xfer;
   word_t            sel_word;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx),
      .any     (rr_any)
   );

   // Occupancy mirror: +1 per word pushed, -1 every 4th clk while non-empty.
   // Credit ignores the same-cycle drain so the word in flight always fits.
   always_comb begin
      drain     = (occ_q != '0) && (phase_q == 2'd3);
      occ_plus  = occ_q + OW'(din_valid_q);
      occ_d     = occ_plus - OW'(drain);
      phase_d   = (occ_q != '0) ? phase_q + 2'd1 : phase_q;
      credit_ok = (occ_plus <= OW'(CAP - 2));
   end

   // Ready generation: the locked owner alone, or the round-robin winner
   always_comb begin
      req_ready = '0;
      if (state_q == LOCK) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == 3'(i)) req_ready[i] = credit_ok;
         end
      end else if (rr_any && credit_ok) begin
         req_ready = rr_gnt;
      end
   end

   // Mux the word and last flag of the requester currently being served
   always_comb begin
      sel_idx  = (state_q == LOCK) ? owner_q : rr_idx;
      sel_word = '0;
      sel_last = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_idx == 3'(i)) begin
            sel_word = req_data[32*i +: 32];
            sel_last = req_last[i];
         end
      end
      xfer = |(req_valid & req_ready);
   end

   // Next state: a non-last word locks the winner, a last word releases it
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      if (xfer) begin
         if (sel_last) begin
            state_d  = ARB;
            rr_ptr_d = (sel_idx == 3'(N_REQ - 1)) ? 3'd0 : sel_idx + 3'd1;
         end else begin
            state_d = LOCK;
            owner_d = sel_idx;
         end
      end
   end

   // Output register, grant tracking and sticky error next values
   always_comb begin
      din_valid_d = xfer;
      din_d       = xfer ? sel_word : din_q;
      grant_id_d  = xfer ? sel_idx : grant_id_q;
      err_d       = err_q | strm_full | (occ_d > OW'(CAP - 1));
   end

   // FSM state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= ARB;
      else       state_q <= state_d;
   end

   // Remaining registers; reset together with the streamer via shared nrst
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         grant_id_q  <= '0;
         din_q       <= '0;
         din_valid_q <= 1'b0;
         occ_q       <= '0;
         phase_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         grant_id_q  <= grant_id_d;
         din_q       <= din_d;
         din_valid_q <= din_valid_d;
         occ_q       <= occ_d;
         phase_q     <= phase_d;
         err_q       <= err_d;
      end
   end

   assign din       = din_q;
   assign din_valid = din_valid_q;
   assign occ       = occ_q;
   assign grant_id  = grant_id_q;
   assign err       = err_q;
   assign idle      = (occ_q == '0) && !din_valid_q && (state_q == ARB);

endmodule
